// File: rtl/load_store_unit.sv
// Load/store unit: drives word-indexed data memory cycles for byte/half/word loads and stores.
// Define LSU_SUBWORD_EN to enable byte/half accesses (read-modify-write for sub-word stores).
module load_store_unit #(
  parameter int MEM_WORDS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic        reqWrite,
  input  logic [1:0]  reqSize,
  input  logic        reqSigned,
  input  logic [31:0] reqAddr,
  input  logic [31:0] reqData,
  output logic        respValid,
  output logic [31:0] respData,
  output logic        respError,
  output logic [31:0] memAdr,
  output logic [31:0] memWriteIn,
  output logic        memWritePin,
  output logic        memReadPin,
  input  logic [31:0] memReadOut
);

  typedef enum logic [2:0] {IDLE, READ, MERGE, WRITE, RESP} state_t;

  typedef struct packed {
    logic        write;
    logic [1:0]  size;
    logic        sgn;
    logic [1:0]  off;
    logic [31:0] data;
  } req_t;

  state_t state;
  req_t   req;

  logic sizeBad, misaligned, outOfRange, reqErr;

`ifdef LSU_SUBWORD_EN
  assign sizeBad = (reqSize == 2'b11);
`else
  assign sizeBad = (reqSize != 2'b10);
`endif
  assign misaligned = (reqSize == 2'b10 && reqAddr[1:0] != 2'b00) ||
                      (reqSize == 2'b01 && reqAddr[0]);
  assign outOfRange = {2'b00, reqAddr[31:2]} >= 32'(MEM_WORDS);
  assign reqErr     = sizeBad || misaligned || outOfRange;

  // Ready is gated by reset so it reads 0 while reset is held and 1 right after.
  assign reqReady = (state == IDLE) && !reset;

  function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] off,
                                          input logic [1:0] size, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (size)
      2'b00:   return {{24{sgn & b[7]}}, b};
      2'b01:   return {{16{sgn & h[15]}}, h};
      default: return w;
    endcase
  endfunction

`ifdef LSU_SUBWORD_EN
  function automatic logic [31:0] mergeLane(input logic [31:0] w, input logic [1:0] off,
                                            input logic [1:0] size, input logic [31:0] d);
    logic [31:0] r;
    r = w;
    if (size == 2'b00) r[{off, 3'b000} +: 8] = d[7:0];
    else               r[{off[1], 4'b0000} +: 16] = d[15:0];
    return r;
  endfunction
`else
  logic unusedReq;
  assign unusedReq = ^{req.write, req.data};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      req         <= '0;
      respValid   <= 1'b0;
      respError   <= 1'b0;
      respData    <= '0;
      memAdr      <= '0;
      memWriteIn  <= '0;
      memWritePin <= 1'b0;
      memReadPin  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (reqValid) begin
          req <= '{write: reqWrite, size: reqSize, sgn: reqSigned,
                   off: reqAddr[1:0], data: reqData};
          memAdr    <= {2'b00, reqAddr[31:2]};
          respData  <= '0;
          respError <= 1'b0;
          if (reqErr) begin
            state     <= RESP;
            respValid <= 1'b1;
            respError <= 1'b1;
          end else if (reqWrite && reqSize == 2'b10) begin
            state       <= WRITE;
            memWritePin <= 1'b1;
            memWriteIn  <= reqData;
          end else begin
            state      <= READ;
            memReadPin <= 1'b1;
          end
        end
        READ: begin
          state      <= MERGE;
          memReadPin <= 1'b0;
        end
        MERGE: begin
`ifdef LSU_SUBWORD_EN
          if (req.write) begin
            state       <= WRITE;
            memWritePin <= 1'b1;
            memWriteIn  <= mergeLane(memReadOut, req.off, req.size, req.data);
          end else
`endif
          begin
            state     <= RESP;
            respValid <= 1'b1;
            respData  <= extract(memReadOut, req.off, req.size, req.sgn);
          end
        end
        WRITE: begin
          state       <= RESP;
          memWritePin <= 1'b0;
          respValid   <= 1'b1;
        end
        RESP: begin
          state     <= IDLE;
          respValid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural word memory model.
module tb_load_store_unit;
  localparam int MEM_WORDS = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        reqValid = 1'b0, reqReady, reqWrite = 1'b0, reqSigned = 1'b0;
  logic [1:0]  reqSize = 2'b10;
  logic [31:0] reqAddr = '0, reqData = '0;
  logic        respValid, respError, memWritePin, memReadPin;
  logic [31:0] respData, memAdr, memWriteIn;
  logic [31:0] memReadOut = '0;

  int nChecks = 0, nErrors = 0;

  load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (
    .clk(clk), .reset(reset),
    .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite), .reqSize(reqSize),
    .reqSigned(reqSigned), .reqAddr(reqAddr), .reqData(reqData),
    .respValid(respValid), .respData(respData), .respError(respError),
    .memAdr(memAdr), .memWriteIn(memWriteIn), .memWritePin(memWritePin),
    .memReadPin(memReadPin), .memReadOut(memReadOut)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [MEM_WORDS];
  always @(posedge clk) begin
    if (memWritePin) mem[memAdr[2:0]] <= memWriteIn;
    if (memReadPin)  memReadOut <= mem[memAdr[2:0]];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Per-cycle observations of one transaction; bit c = cycle c after accept.
  logic [6:0]  rpV, wpV, rvV;
  logic [31:0] rdat, wdat, adrAt;
  logic        rerr;

  task automatic doReq(input logic wr, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] d);
    rpV = '0; wpV = '0; rvV = '0; rdat = '0; wdat = '0; adrAt = '0; rerr = 1'b0;
    @(negedge clk);
    chk("ready before req", 32'(reqReady), 32'd1);
    reqValid = 1'b1; reqWrite = wr; reqSize = sz; reqSigned = sg; reqAddr = a; reqData = d;
    @(posedge clk); #1 reqValid = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      rpV[c] = memReadPin; wpV[c] = memWritePin; rvV[c] = respValid;
      if (respValid) begin rdat = respData; rerr = respError; end
      if (memWritePin) wdat = memWriteIn;
      if (c == 1) adrAt = memAdr;
      @(posedge clk); #1;
    end
  endtask

  task automatic expectResp(input string t, input logic [6:0] eRp, input logic [6:0] eWp,
                            input logic [6:0] eRv, input logic [31:0] eData, input logic eErr);
    chk({t, " readPin cycles"},  32'(rpV), 32'(eRp));
    chk({t, " writePin cycles"}, 32'(wpV), 32'(eWp));
    chk({t, " respValid cycles"}, 32'(rvV), 32'(eRv));
    chk({t, " respData"},  rdat, eData);
    chk({t, " respError"}, 32'(rerr), 32'(eErr));
  endtask

  // Accept a request, raise reset in cycle 2, and confirm it was abandoned.
  task automatic resetMid(input logic wr, input logic [1:0] sz, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] expWord);
    wpV = '0; rvV = '0;
    @(negedge clk);
    reqValid = 1'b1; reqWrite = wr; reqSize = sz; reqSigned = 1'b0; reqAddr = a; reqData = d;
    @(posedge clk); #1 reqValid = 1'b0;
    wpV[1] = memWritePin; rvV[1] = respValid;
    @(posedge clk); #1 reset = 1'b1;
    wpV[2] = memWritePin; rvV[2] = respValid;
    @(posedge clk); #1;
    chk("rst held reqReady", 32'(reqReady), 32'd0);
    chk("rst held readPin", 32'(memReadPin), 32'd0);
    wpV[3] = memWritePin; rvV[3] = respValid;
    reset = 1'b0;
    for (int c = 4; c <= 6; c++) begin
      @(posedge clk); #1;
      if (c == 4) chk("rst reqReady after", 32'(reqReady), 32'd1);
      wpV[c] = memWritePin; rvV[c] = respValid;
    end
    chk("rst no writePin", 32'(wpV), 32'd0);
    chk("rst no respValid", 32'(rvV), 32'd0);
    chk("rst word3 intact", mem[3], expWord);
  endtask

  logic [31:0] word3;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset reqReady", 32'(reqReady), 32'd0);
    chk("reset respValid", 32'(respValid), 32'd0);
    chk("reset respError", 32'(respError), 32'd0);
    chk("reset readPin", 32'(memReadPin), 32'd0);
    chk("reset writePin", 32'(memWritePin), 32'd0);
    chk("reset respData", respData, 32'd0);
    chk("reset memAdr", memAdr, 32'd0);
    chk("reset memWriteIn", memWriteIn, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("reqReady after reset", 32'(reqReady), 32'd1);

    doReq(1'b1, 2'b10, 1'b0, 32'h0C, 32'hDEADBEEF);
    expectResp("word store", 7'b0000000, 7'b0000010, 7'b0000100, 32'h0, 1'b0);
    chk("word store memAdr", adrAt, 32'd3);
    chk("word store writeIn", wdat, 32'hDEADBEEF);
    chk("word store mem3", mem[3], 32'hDEADBEEF);

    doReq(1'b0, 2'b10, 1'b0, 32'h0C, 32'h0);
    expectResp("word load", 7'b0000010, 7'b0000000, 7'b0001000, 32'hDEADBEEF, 1'b0);
    word3 = 32'hDEADBEEF;

    doReq(1'b0, 2'b10, 1'b0, 32'h0E, 32'h0);
    expectResp("misaligned word", 7'b0, 7'b0, 7'b0000010, 32'h0, 1'b1);
    doReq(1'b1, 2'b10, 1'b0, 32'h20, 32'h12345678);
    expectResp("out of range word", 7'b0, 7'b0, 7'b0000010, 32'h0, 1'b1);
    doReq(1'b0, 2'b11, 1'b0, 32'h0C, 32'h0);
    expectResp("illegal size", 7'b0, 7'b0, 7'b0000010, 32'h0, 1'b1);

`ifdef LSU_SUBWORD_EN
    doReq(1'b1, 2'b00, 1'b0, 32'h0D, 32'h00000055);
    expectResp("byte store", 7'b0000010, 7'b0001000, 7'b0010000, 32'h0, 1'b0);
    chk("byte store writeIn", wdat, 32'hDEAD55EF);
    chk("byte store mem3", mem[3], 32'hDEAD55EF);
    word3 = 32'hDEAD55EF;
    doReq(1'b0, 2'b00, 1'b1, 32'h0F, 32'h0);
    expectResp("sbyte load", 7'b0000010, 7'b0, 7'b0001000, 32'hFFFFFFDE, 1'b0);
    doReq(1'b0, 2'b00, 1'b0, 32'h0F, 32'h0);
    expectResp("ubyte load", 7'b0000010, 7'b0, 7'b0001000, 32'h000000DE, 1'b0);
    doReq(1'b0, 2'b01, 1'b1, 32'h0E, 32'h0);
    expectResp("shalf load", 7'b0000010, 7'b0, 7'b0001000, 32'hFFFFDEAD, 1'b0);
    doReq(1'b0, 2'b01, 1'b0, 32'h0C, 32'h0);
    expectResp("uhalf load", 7'b0000010, 7'b0, 7'b0001000, 32'h000055EF, 1'b0);
    doReq(1'b0, 2'b01, 1'b0, 32'h0D, 32'h0);
    expectResp("misaligned half", 7'b0, 7'b0, 7'b0000010, 32'h0, 1'b1);
    resetMid(1'b1, 2'b00, 32'h0D, 32'h000000AA, word3);
`else
    doReq(1'b0, 2'b00, 1'b0, 32'h0C, 32'h0);
    expectResp("byte load disabled", 7'b0, 7'b0, 7'b0000010, 32'h0, 1'b1);
    doReq(1'b1, 2'b01, 1'b0, 32'h0C, 32'h0000AAAA);
    expectResp("half store disabled", 7'b0, 7'b0, 7'b0000010, 32'h0, 1'b1);
    resetMid(1'b0, 2'b10, 32'h0C, 32'h0, word3);
`endif

    doReq(1'b0, 2'b10, 1'b0, 32'h0C, 32'h0);
    expectResp("final word load", 7'b0000010, 7'b0000000, 7'b0001000, word3, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
